// File: rtl/ram_arbiter_pkg.sv
// Shared configuration for the RAM arbiter: owner encoding, lock defaults, RAM address map.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package ram_arbiter_pkg;

  // Bus ownership state; also reused to name the last granted requester.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  // RAM address map: one word-addressed region starting at word 0.
  localparam int RAM_ADDR_W_DEFAULT = 32;

  // Burst locking.
  localparam int LOCK_MAX_DEFAULT = 8;
  localparam int LOCK_CNT_W       = 8;

  // Next burst count for an owner that is granted again; sticks at lock_max.
  function automatic logic [LOCK_CNT_W-1:0] lock_cnt_inc(
    input logic [LOCK_CNT_W-1:0] cnt,
    input int unsigned           lock_max
  );
    if (cnt >= LOCK_CNT_W'(lock_max)) begin
      return LOCK_CNT_W'(lock_max);
    end
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection between CPU and DMA for the shared RAM port.
// Latency: purely combinational, zero cycles.
// Backpressure: the losing request stays pending upstream; nothing is stored here.
//
// Ports:
//   cpu_req_i / dma_req_i : pending requests
//   owner_i, lock_cnt_i   : current burst owner and grants it has taken so far
//   last_grant_i          : last granted requester (used only by the round-robin tie-break)
//   cpu_win_o / dma_win_o : one-hot (or zero) winner
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin instead of CPU-first tie-break.
module ram_arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic                  cpu_req_i,
  input  logic                  dma_req_i,
  input  owner_e                owner_i,
  input  logic [LOCK_CNT_W-1:0] lock_cnt_i,
  input  owner_e                last_grant_i,
  output logic                  cpu_win_o,
  output logic                  dma_win_o
);

  logic burst_left;

  always_comb begin
    cpu_win_o  = 1'b0;
    dma_win_o  = 1'b0;
    burst_left = (lock_cnt_i < LOCK_CNT_W'(LOCK_MAX));

    if (owner_i == OWN_CPU && cpu_req_i) begin
      // An exhausted burst only yields if the other side is actually waiting.
      if (burst_left || !dma_req_i) cpu_win_o = 1'b1;
      else                          dma_win_o = 1'b1;
    end else if (owner_i == OWN_DMA && dma_req_i) begin
      if (burst_left || !cpu_req_i) dma_win_o = 1'b1;
      else                          cpu_win_o = 1'b1;
    end else if (cpu_req_i && dma_req_i) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (last_grant_i == OWN_CPU) dma_win_o = 1'b1;
      else                         cpu_win_o = 1'b1;
`else
      cpu_win_o = 1'b1;
`endif
    end else begin
      cpu_win_o = cpu_req_i;
      dma_win_o = dma_req_i;
    end
  end

`ifndef RAM_ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = (last_grant_i == OWN_DMA);
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester (CPU, DMA) arbiter in front of a single-port synchronous RAM, with burst locking.
// Latency: grant and RAM command combinational in the request cycle; read data/rvalid one cycle later.
// Backpressure: an ungranted request is simply not granted and must be held by the requester.
//
// Ports:
//   clk, rst_n                         : clock, async active-low reset (forces all outputs to 0)
//   {cpu,dma}_req/we/lock/addr/wdata/wstrb : requester command
//   {cpu,dma}_gnt                      : request accepted this cycle
//   {cpu,dma}_rvalid, rdata            : read return (rdata is 0 when no rvalid)
//   ram_en/we/addr/wdata/wstrb, ram_rdata : RAM port
// Build option: RAM_ARB_ROUND_ROBIN_EN enables round-robin tie-break (default: CPU wins ties).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W_DEFAULT,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic [3:0]        dma_wstrb,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wstrb,
  input  logic [31:0]       ram_rdata
);

  owner_e                owner_q, owner_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  cpu_rvalid_q, dma_rvalid_q;
  owner_e                last_grant;
  logic                  cpu_win, dma_win;

  ram_arb_pick #(
    .LOCK_MAX(LOCK_MAX)
  ) u_pick (
    .cpu_req_i   (cpu_req),
    .dma_req_i   (dma_req),
    .owner_i     (owner_q),
    .lock_cnt_i  (lock_cnt_q),
    .last_grant_i(last_grant),
    .cpu_win_o   (cpu_win),
    .dma_win_o   (dma_win)
  );

  // Gating with rst_n keeps every output at 0 during reset and drops a grant
  // that coincides with reset assertion before it can reach the RAM.
  assign cpu_gnt = cpu_win & rst_n;
  assign dma_gnt = dma_win & rst_n;

  always_comb begin
    ram_en    = cpu_gnt | dma_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = '0;
    if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_wstrb = cpu_wstrb;
    end else if (dma_gnt) begin
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_wstrb = dma_wstrb;
    end
  end

  // Ownership: a locked grant takes (or keeps) the bus, an unlocked grant or an
  // owner that stops requesting releases it. Count restarts at 1 on a new owner
  // so the acquiring grant counts toward the burst limit.
  always_comb begin
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (cpu_gnt) begin
      if (cpu_lock) begin
        owner_d    = OWN_CPU;
        lock_cnt_d = (owner_q == OWN_CPU) ? lock_cnt_inc(lock_cnt_q, LOCK_MAX) : LOCK_CNT_W'(1);
      end else begin
        owner_d    = OWN_NONE;
        lock_cnt_d = '0;
      end
    end else if (dma_gnt) begin
      if (dma_lock) begin
        owner_d    = OWN_DMA;
        lock_cnt_d = (owner_q == OWN_DMA) ? lock_cnt_inc(lock_cnt_q, LOCK_MAX) : LOCK_CNT_W'(1);
      end else begin
        owner_d    = OWN_NONE;
        lock_cnt_d = '0;
      end
    end else if ((owner_q == OWN_CPU && !cpu_req) || (owner_q == OWN_DMA && !dma_req)) begin
      owner_d    = OWN_NONE;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      lock_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dma_rvalid_q <= dma_gnt & ~dma_we;
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  owner_e last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (cpu_gnt)      last_grant_d = OWN_CPU;
    else if (dma_gnt) last_grant_d = OWN_DMA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= OWN_CPU;
    else        last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_CPU;
`endif

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign rdata      = (cpu_rvalid_q | dma_rvalid_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 4 units after posedge.
// Backpressure: stimulus holds each request until the model says it was granted.
module tb_ram_arbiter;

  localparam int AW = 16;
  localparam int LM = 4;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_lock, dma_req, dma_we, dma_lock;
  logic [AW-1:0] cpu_addr, dma_addr, ram_addr;
  logic [31:0]   cpu_wdata, dma_wdata, ram_wdata, ram_rdata, rdata;
  logic [3:0]    cpu_wstrb, dma_wstrb, ram_wstrb;
  logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_en, ram_we;

  int errors = 0;
  int checks = 0;

  // Reference model state: owner 0=none 1=cpu 2=dma; burst count; last winner; expected rvalids.
  int m_owner, m_cnt, m_last;
  bit m_rv_cpu, m_rv_dma;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
  );

  // A requester must not alter its command while it is waiting for a grant.
  logic          cpu_hold = 1'b0, dma_hold = 1'b0;
  logic [AW-1:0] cpu_addr_p, dma_addr_p;
  logic [31:0]   cpu_wdata_p, dma_wdata_p;
  logic          cpu_we_p, dma_we_p;
  always @(posedge clk) begin
    if (rst_n && cpu_hold && cpu_req)
      assert (cpu_addr == cpu_addr_p && cpu_we == cpu_we_p && cpu_wdata == cpu_wdata_p)
        else $error("cpu command changed while pending");
    if (rst_n && dma_hold && dma_req)
      assert (dma_addr == dma_addr_p && dma_we == dma_we_p && dma_wdata == dma_wdata_p)
        else $error("dma command changed while pending");
    cpu_hold <= rst_n && cpu_req && !cpu_gnt;
    dma_hold <= rst_n && dma_req && !dma_gnt;
    cpu_addr_p <= cpu_addr; cpu_we_p <= cpu_we; cpu_wdata_p <= cpu_wdata;
    dma_addr_p <= dma_addr; dma_we_p <= dma_we; dma_wdata_p <= dma_wdata;
  end

  task automatic drive_idle();
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0; dma_wstrb = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    drive_idle();
    ram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    m_owner = 0; m_cnt = 0; m_last = 1; m_rv_cpu = 0; m_rv_dma = 0;
  endtask

  // Winner according to the arbitration rules (0 none, 1 cpu, 2 dma).
  function automatic int model_pick(input bit creq, input bit dreq);
    bit c_owns = (m_owner == 1) && creq;
    bit d_owns = (m_owner == 2) && dreq;
    if (c_owns) return (m_cnt < LM || !dreq) ? 1 : 2;
    if (d_owns) return (m_cnt < LM || !creq) ? 2 : 1;
    if (creq && dreq) return RR ? ((m_last == 1) ? 2 : 1) : 1;
    if (creq) return 1;
    if (dreq) return 2;
    return 0;
  endfunction

  task automatic model_step(input int g);
    bit lk;
    m_rv_cpu = (g == 1) && !cpu_we;
    m_rv_dma = (g == 2) && !dma_we;
    if (g != 0) begin
      lk = (g == 1) ? cpu_lock : dma_lock;
      if (lk) begin
        m_cnt   = (m_owner == g) ? ((m_cnt + 1 > LM) ? LM : m_cnt + 1) : 1;
        m_owner = g;
      end else begin
        m_owner = 0;
        m_cnt   = 0;
      end
      m_last = g;
    end else if (m_owner != 0) begin
      // No grant while owned can only mean the owner stopped requesting.
      m_owner = 0;
      m_cnt   = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0005; cpu_wdata = 32'hCAFE0001; cpu_wstrb = 4'hF;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0007; dma_wdata = 32'hCAFE0002; dma_wstrb = 4'hF;
    ram_rdata = 32'hFFFFFFFF;
    #3;
    checks++; if ({cpu_gnt, dma_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b required 00", {cpu_gnt, dma_gnt}); end
    checks++; if ({ram_en, ram_we, ram_wstrb} !== 6'b0) begin errors++; $display("FAIL reset_ram_ctl: got %b required 0", {ram_en, ram_we, ram_wstrb}); end
    checks++; if ({ram_addr, ram_wdata} !== '0) begin errors++; $display("FAIL reset_ram_data: addr=%h wdata=%h required 0", ram_addr, ram_wdata); end
    checks++; if ({cpu_rvalid, dma_rvalid, rdata} !== '0) begin errors++; $display("FAIL reset_rd: rv=%b%b rdata=%h required 0", cpu_rvalid, dma_rvalid, rdata); end
    checks++; if (dut.owner_q !== 2'd0 || dut.lock_cnt_q !== 8'd0) begin errors++; $display("FAIL reset_state: owner=%0d cnt=%0d required 0 0", dut.owner_q, dut.lock_cnt_q); end
    next_cycle();
    // First edge after release must already grant.
    rst_n = 1; dma_req = 0; cpu_we = 0;
    m_owner = 0; m_cnt = 0; m_last = 1; m_rv_cpu = 0; m_rv_dma = 0;
    #3;
    checks++; if (cpu_gnt !== 1'b1 || ram_addr !== 16'h0005) begin errors++; $display("FAIL reset_first_gnt: gnt=%b addr=%h required 1 0005", cpu_gnt, ram_addr); end
    next_cycle();
    cpu_req = 0;
    #3;
    checks++; if (cpu_rvalid !== 1'b1 || rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_first_rd: rv=%b rdata=%h required 1 ffffffff", cpu_rvalid, rdata); end
    next_cycle();
  endtask

  task automatic test_single_read();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    #3;
    checks++; if ({cpu_gnt, dma_gnt} !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b required 10", {cpu_gnt, dma_gnt}); end
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'h0010) begin errors++; $display("FAIL rd_cmd: en=%b we=%b addr=%h required 1 0 0010", ram_en, ram_we, ram_addr); end
    next_cycle();
    cpu_req = 0; ram_rdata = 32'hDEADBEEF;
    #3;
    checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b10) begin errors++; $display("FAIL rd_rvalid: got %b required 10", {cpu_rvalid, dma_rvalid}); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h required deadbeef", rdata); end
    next_cycle();
    #3;
    checks++; if (cpu_rvalid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rd_after: rv=%b rdata=%h required 0 0", cpu_rvalid, rdata); end
  endtask

  task automatic test_alternate();
    apply_reset();
    cpu_we = 1; cpu_addr = 16'h0100; dma_we = 1; dma_addr = 16'h0200;
    dma_req = 1;
    #3;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL alt_dma_only: got %b required 1", dma_gnt); end
    next_cycle();
    cpu_req = 1;
    for (int i = 0; i < 8; i++) begin
      bit exp_cpu = RR ? (i % 2 == 0) : 1'b1;
      #3;
      checks++; if ({cpu_gnt, dma_gnt} !== {exp_cpu, !exp_cpu}) begin errors++; $display("FAIL alt_gnt[%0d]: got %b required %b", i, {cpu_gnt, dma_gnt}, {exp_cpu, !exp_cpu}); end
      checks++; if (ram_addr !== (exp_cpu ? 16'h0100 : 16'h0200)) begin errors++; $display("FAIL alt_addr[%0d]: got %h", i, ram_addr); end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_lock_burst();
    apply_reset();
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 16'h0040;
    for (int i = 0; i < 6; i++) begin
      bit exp_cpu   = (i == 4) || (i == 5 && !RR);
      int exp_cnt   = (i >= 1 && i <= 4) ? i : 0;
      int exp_owner = (i >= 1 && i <= 4) ? 2 : 0;
      if (i == 1) begin cpu_req = 1; cpu_we = 1; cpu_lock = 0; cpu_addr = 16'h0041; end
      #3;
      checks++; if ({cpu_gnt, dma_gnt} !== {exp_cpu, !exp_cpu}) begin errors++; $display("FAIL lock_gnt[%0d]: got %b required %b", i, {cpu_gnt, dma_gnt}, {exp_cpu, !exp_cpu}); end
      checks++; if (int'(dut.lock_cnt_q) != exp_cnt || int'(dut.owner_q) != exp_owner) begin errors++; $display("FAIL lock_state[%0d]: cnt=%0d owner=%0d required %0d %0d", i, dut.lock_cnt_q, dut.owner_q, exp_cnt, exp_owner); end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_write();
    apply_reset();
    cpu_req = 1; cpu_we = 1; cpu_wstrb = 4'b0011; cpu_wdata = 32'h12345678; cpu_addr = 16'h0022;
    #3;
    checks++; if (cpu_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL wr_ctl: gnt=%b en=%b we=%b required 1 1 1", cpu_gnt, ram_en, ram_we); end
    checks++; if (ram_wstrb !== 4'b0011 || ram_wdata !== 32'h12345678 || ram_addr !== 16'h0022) begin errors++; $display("FAIL wr_data: strb=%b wdata=%h addr=%h required 0011 12345678 0022", ram_wstrb, ram_wdata, ram_addr); end
    next_cycle();
    cpu_req = 0; ram_rdata = 32'hA5A5A5A5;
    #3;
    checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00 || rdata !== 32'h0) begin errors++; $display("FAIL wr_no_rvalid: rv=%b%b rdata=%h required 00 0", cpu_rvalid, dma_rvalid, rdata); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 16'h0033;
    #3;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rst_rd_gnt: got %b required 1", dma_gnt); end
    rst_n = 0;
    #1;
    checks++; if (dma_gnt !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL rst_rd_gate: gnt=%b en=%b required 0 0", dma_gnt, ram_en); end
    next_cycle();
    rst_n = 1; dma_req = 0; dma_lock = 0; ram_rdata = 32'h5555AAAA;
    #3;
    checks++; if (dma_rvalid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_rd_drop: rv=%b rdata=%h required 0 0", dma_rvalid, rdata); end
    checks++; if (dut.owner_q !== 2'd0 || {cpu_gnt, dma_gnt, ram_en, ram_addr} !== '0) begin errors++; $display("FAIL rst_rd_idle: owner=%0d gnt=%b%b en=%b", dut.owner_q, cpu_gnt, dma_gnt, ram_en); end
    next_cycle();
    #3;
    checks++; if ({cpu_rvalid, dma_rvalid, ram_en} !== 3'b000) begin errors++; $display("FAIL rst_rd_quiet: got %b required 000", {cpu_rvalid, dma_rvalid, ram_en}); end
  endtask

  task automatic test_random();
    bit c_pend = 0, d_pend = 0;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      int          g;
      logic        e_we;
      logic [AW-1:0] e_addr;
      logic [31:0] e_wdata, e_rdata;
      logic [3:0]  e_wstrb;
      if (!c_pend) begin
        cpu_req = ($urandom_range(0, 99) < 65); cpu_lock = 1'($urandom_range(0, 1));
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom);
        cpu_wdata = $urandom; cpu_wstrb = 4'($urandom_range(0, 15));
      end
      if (!d_pend) begin
        dma_req = ($urandom_range(0, 99) < 65); dma_lock = 1'($urandom_range(0, 1));
        dma_we = 1'($urandom_range(0, 1)); dma_addr = AW'($urandom);
        dma_wdata = $urandom; dma_wstrb = 4'($urandom_range(0, 15));
      end
      ram_rdata = $urandom;
      #3;
      g = model_pick(cpu_req, dma_req);
      e_we    = (g == 1) ? cpu_we    : (g == 2) ? dma_we    : 1'b0;
      e_addr  = (g == 1) ? cpu_addr  : (g == 2) ? dma_addr  : '0;
      e_wdata = (g == 1) ? cpu_wdata : (g == 2) ? dma_wdata : '0;
      e_wstrb = (g == 1) ? cpu_wstrb : (g == 2) ? dma_wstrb : '0;
      e_rdata = (m_rv_cpu || m_rv_dma) ? ram_rdata : 32'h0;
      checks++; if ({cpu_gnt, dma_gnt} !== {g == 1, g == 2}) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b required %b", n, {cpu_gnt, dma_gnt}, {g == 1, g == 2}); end
      checks++; if (ram_en !== (g != 0) || ram_we !== e_we) begin errors++; $display("FAIL rnd_ctl[%0d]: en=%b we=%b required %b %b", n, ram_en, ram_we, g != 0, e_we); end
      checks++; if (ram_addr !== e_addr || ram_wdata !== e_wdata || ram_wstrb !== e_wstrb) begin errors++; $display("FAIL rnd_cmd[%0d]: addr=%h wdata=%h strb=%b required %h %h %b", n, ram_addr, ram_wdata, ram_wstrb, e_addr, e_wdata, e_wstrb); end
      checks++; if ({cpu_rvalid, dma_rvalid} !== {m_rv_cpu, m_rv_dma}) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b required %b", n, {cpu_rvalid, dma_rvalid}, {m_rv_cpu, m_rv_dma}); end
      checks++; if (rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h required %h", n, rdata, e_rdata); end
      c_pend = cpu_req && (g != 1);
      d_pend = dma_req && (g != 2);
      model_step(g);
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    rst_n = 1;
    drive_idle();
    ram_rdata = '0;
    #2;
    rst_n = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_write();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the RAM word-address width in bits.
REQ-002 SHALL have parameter LOCK_MAX, default 8, meaning the maximum consecutive locked grants to one requester (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports cpu_req / dma_req, input, 1 bit each: a transaction is requested and held until granted.
REQ-006 SHALL have ports cpu_we / dma_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports cpu_lock / dma_lock, input, 1 bit each: the requester asks to keep ownership for a burst.
REQ-008 SHALL have ports cpu_addr / dma_addr, input, ADDR_W bits each: the word address.
REQ-009 SHALL have ports cpu_wdata / dma_wdata and cpu_wstrb / dma_wstrb, input, 32 / 4 bits: the write data and byte enables.
REQ-010 SHALL have ports cpu_gnt / dma_gnt, output, 1 bit each: the request is accepted this cycle.
REQ-011 SHALL have ports cpu_rvalid / dma_rvalid, output, 1 bit each: read data valid.
REQ-012 SHALL have port rdata, output, 32 bits: read data shared by both requesters.
REQ-013 SHALL have ports ram_en, ram_we, ram_addr, ram_wdata, ram_wstrb, output, 1/1/ADDR_W/32/4 bits: the single-port RAM command.
REQ-014 SHALL have port ram_rdata, input, 32 bits: RAM read data, valid one cycle after ram_en with ram_we=0.

Function
REQ-015 SHALL grant at most one requester per cycle; the grant is combinational from req and registered state, with no added latency.
REQ-016 SHALL drive the ram_* outputs from the granted requester's signals in the grant cycle; ram_en=0 and all other ram_* outputs =0 when there is no grant.
REQ-017 SHALL assert <x>_rvalid exactly one cycle after a read grant to <x>, with rdata=ram_rdata; rdata SHALL be 0 when no rvalid is asserted.
REQ-018 SHALL ensure a write grant produces no rvalid.
REQ-019 SHALL track state OWNER in {NONE, CPU, DMA} plus an 8-bit lock_cnt.
REQ-020 SHALL move OWNER to X after a grant to X with X_lock=1; SHALL return OWNER to NONE after a grant with lock=0, or when the owner deasserts req.
REQ-021 SHALL give the owner absolute priority while OWNER=X and X_req=1 and lock_cnt<LOCK_MAX.
REQ-022 SHALL, on lock_cnt reaching LOCK_MAX with the other requester pending, grant the other requester next; OWNER then becomes NONE (or the other requester, if it asserts lock) and lock_cnt clears.
REQ-023 SHALL increment lock_cnt on each owner grant, saturating at LOCK_MAX, and clear it on any owner change.
REQ-024 SHALL grant immediately with no idle cycle when a single requester is present.
REQ-025 SHALL, on simultaneous requests with OWNER=NONE, resolve per REQ-031/REQ-032.
REQ-026 SHALL keep an ungranted request pending; a requester SHALL NOT change addr/we/wdata until granted (bench assertion).

Reset
REQ-027 SHALL, while rst_n=0: OWNER=NONE, lock_cnt=0, last_grant=CPU, rvalid pipeline=0, all outputs 0.
REQ-028 SHALL drop a read granted in the cycle rst_n asserts: no rvalid after reset release.
REQ-029 SHALL allow the first grant in the first clock edge after rst_n deasserts.

Configuration
REQ-030 SHALL have macro RAM_ARB_ROUND_ROBIN_EN.
REQ-031 SHALL, with RAM_ARB_ROUND_ROBIN_EN defined, resolve simultaneous non-owner requests by round-robin: the requester not granted last wins; last_grant updates on every grant.
REQ-032 SHALL, without RAM_ARB_ROUND_ROBIN_EN, resolve them by fixed priority: CPU wins; last_grant is unused; lock and LOCK_MAX behaviour are unchanged.

Structure
REQ-033 SHALL place the OWNER encoding (NONE=2'd0, CPU=2'd1, DMA=2'd2) and the default LOCK_MAX in the shared config header alongside the RAM address map.
REQ-034 SHALL use one sub-module, ram_arb_pick: pure combinational winner selection from reqs, OWNER, lock_cnt and last_grant.

Verification
REQ-035 SHALL cover: single requester, CPU read addr 0x10, then RAM returns 0xDEADBEEF -> cpu_gnt in cycle 0, cpu_rvalid=1 and rdata=0xDEADBEEF in cycle 1, no dma_rvalid.
REQ-036 SHALL cover: both req continuously, no lock, RR build -> grants alternate CPU, DMA, CPU, DMA...; fixed build -> CPU every cycle.
REQ-037 SHALL cover: DMA lock burst with CPU pending, LOCK_MAX=4 -> 4 consecutive dma_gnt, then cpu_gnt, lock_cnt=0.
REQ-038 SHALL cover: CPU write with wstrb=4'b0011, wdata=0x12345678 -> ram_we=1 and ram_wstrb=0011 in the grant cycle, no rvalid next cycle.
REQ-039 SHALL cover: rst_n low in the cycle of a DMA read grant -> no dma_rvalid, OWNER=NONE, all outputs 0 until the next request.
